// File: rtl/pwm_pkg.sv
// Shared types for the PWM timing blocks: timer run mode and timer FSM state.
package pwm_pkg;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } timer_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..ratio and raises tick on the cycle it sits at ratio.
module tick_gen #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] ratio,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_reg;

  // Decoded from the prescaler register, so a ratio of 0 ticks on every enabled cycle.
  assign tick = enable && (presc_reg == ratio);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (clear) begin
      presc_reg <= '0;
    end else if (enable) begin
      if (presc_reg == ratio) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable period timer: counts prescaled ticks 0..N, pulses done on each wrap,
// periodic or one-shot, with start/stop control and a live count.
module prog_timer
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  done,
  output logic                  busy
);

  timer_state_t          state_reg;
  timer_mode_t           mode_reg;
  logic [WIDTH-1:0]      n_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [WIDTH-1:0]      count_reg;
  logic                  done_reg;
  logic                  busy_reg;
  logic                  tick;

  assign count = count_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (start || stop),
    .enable(enable && (state_reg == RUN)),
    .ratio (prescale_reg),
    .tick  (tick)
  );

  // stop beats start, and both beat a coincident wrap, so neither ever emits done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      mode_reg     <= PERIODIC;
      n_reg        <= '0;
      prescale_reg <= '0;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (stop) begin
        state_reg <= IDLE;
        count_reg <= '0;
        busy_reg  <= 1'b0;
      end else if (start) begin
        state_reg    <= RUN;
        count_reg    <= '0;
        busy_reg     <= 1'b1;
        n_reg        <= period;
        prescale_reg <= prescale;
        mode_reg     <= timer_mode_t'(mode);
      end else if ((state_reg == RUN) && tick) begin
        if (count_reg == n_reg) begin
          count_reg <= '0;
          done_reg  <= 1'b1;
          n_reg     <= period;
          if (mode_reg == ONESHOT) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

endmodule
